// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline forwarding, stall/flush control, hazard FSM and performance counters
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   Rs1_D/Rs2_D, Rs1_E/Rs2_E  source registers in Decode / Execute
//   RdE/RdM/RdW               destination registers in Execute / Memory / Writeback
//   RegWriteM/RegWriteW       write enables in Memory / Writeback
//   LoadE, PCSrcE             load in Execute, taken branch resolved in Execute
//   MemReqM, MemReadyM        data-memory handshake in Memory
//   ForwardAE/ForwardBE       ALU operand select (10 Memory, 01 Writeback, 00 register file)
//   Stall*/Flush*             pipeline register hold / bubble controls
//   State                     registered hazard state (RUN, LU, BR, MWAIT)
//   StallCount/FlushCount     saturating performance counters
//   MemTimeout                sticky memory-wait error flag
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic [1:0]        State,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount,
  output logic              MemTimeout
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN = 2'b00, LU = 2'b01, BR = 2'b10, MWAIT = 2'b11} state_t;
  state_t st;
  logic [WW-1:0] waitCnt;
  logic memStall, lwStall, brFlush, brAct, lwAct;
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs);
    return (RegWriteM && RdM != '0 && RdM == rs) ? 2'b10 :
           (RegWriteW && RdW != '0 && RdW == rs) ? 2'b01 : 2'b00;
  endfunction
  assign memStall = MemReqM & ~MemReadyM;
  assign lwStall = LoadE & (RdE != '0) & (RdE == Rs1_D | RdE == Rs2_D);
  assign brFlush = PCSrcE;
  // A memory wait holds everything, so a branch or load-use is only acted on without it.
  assign brAct = ~rst & ~memStall & brFlush;
  assign lwAct = ~rst & ~memStall & ~brFlush & lwStall;
  assign ForwardAE = rst ? 2'b00 : fwdSel(Rs1_E);
  assign ForwardBE = rst ? 2'b00 : fwdSel(Rs2_E);
  assign StallF = (~rst & memStall) | lwAct;
  assign StallD = (~rst & memStall) | lwAct;
  assign StallE = ~rst & memStall;
  assign StallM = ~rst & memStall;
  assign FlushW = ~rst & memStall;
  assign FlushD = brAct;
  assign FlushE = brAct | lwAct;
  assign State = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      waitCnt <= '0;
      StallCount <= '0;
      FlushCount <= '0;
      MemTimeout <= 1'b0;
    end else begin
      st <= memStall ? MWAIT : brFlush ? BR : lwStall ? LU : RUN;
      waitCnt <= !memStall ? '0 : (waitCnt == WW'(MEM_TIMEOUT)) ? waitCnt : waitCnt + 1'b1;
      if (memStall && waitCnt == WW'(MEM_TIMEOUT - 1)) MemTimeout <= 1'b1;
      if (StallF && !(&StallCount)) StallCount <= StallCount + 1'b1;
      if (FlushD && !(&FlushCount)) FlushCount <= FlushCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;
  logic clk = 1'b0, rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RdE, RdM, RdW;
  logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE, State, ForwardAE4, ForwardBE4, State4;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic StallF4, StallD4, StallE4, StallM4, FlushD4, FlushE4, FlushW4, MemTimeout4;
  logic [15:0] StallCount, FlushCount;
  logic [3:0] StallCount4, FlushCount4;
  logic [6:0] sf;
  int nChecks = 0, nErr = 0;
  always #5 clk = ~clk;
  assign sf = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  hazard_ctrl_unit dut (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .State(State), .StallCount(StallCount), .FlushCount(FlushCount), .MemTimeout(MemTimeout)
  );
  hazard_ctrl_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4), .StallF(StallF4), .StallD(StallD4),
    .StallE(StallE4), .StallM(StallM4), .FlushD(FlushD4), .FlushE(FlushE4), .FlushW(FlushW4),
    .State(State4), .StallCount(StallCount4), .FlushCount(FlushCount4), .MemTimeout(MemTimeout4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clearIn();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask
  initial begin
    clearIn();
    rst = 1'b1;
    LoadE = 1'b1; RdE = 5'd3; Rs1_D = 5'd3; RegWriteM = 1'b1; RdM = 5'd7; Rs1_E = 5'd7;
    #1;
    check("rst_sf", 32'(sf), 32'h0);
    check("rst_fwdA", 32'(ForwardAE), 32'h0);
    step();
    check("rst_state", 32'(State), 32'h0);
    check("rst_cnt", 32'({StallCount, FlushCount}), 32'h0);
    check("rst_to", 32'(MemTimeout), 32'h0);
    clearIn();
    rst = 1'b0;
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1_E = 5'd5; Rs2_E = 5'd0;
    #1;
    check("fwdA_mem", 32'(ForwardAE), 32'h2);
    check("fwdB_r0", 32'(ForwardBE), 32'h0);
    RegWriteM = 1'b0;
    #1;
    check("fwdA_wb", 32'(ForwardAE), 32'h1);
    Rs2_E = 5'd5; RegWriteM = 1'b1;
    #1;
    check("fwdB_mem_prio", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0; RdW = 5'd0; Rs1_E = 5'd0;
    #1;
    check("fwdA_none", 32'(ForwardAE), 32'h0);
    check("sf_idle", 32'(sf), 32'h0);
    clearIn();
    LoadE = 1'b1; RdE = 5'd3; Rs2_D = 5'd3;
    #1;
    check("lu_sf", 32'(sf), 32'b1100010);
    step();
    check("lu_state", 32'(State), 32'h1);
    check("lu_cnt", 32'(StallCount), 32'd1);
    PCSrcE = 1'b1;
    #1;
    check("br_sf", 32'(sf), 32'b0000110);
    step();
    check("br_fcnt", 32'(FlushCount), 32'd1);
    check("br_state", 32'(State), 32'h2);
    check("br_scnt", 32'(StallCount), 32'd1);
    clearIn();
    step();
    check("idle_state", 32'(State), 32'h0);
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("mw_sf%0d", i), 32'(sf), 32'b1111001);
      if (i == 7) check("mw_to_pre", 32'(MemTimeout), 32'h0);
      step();
    end
    check("mw_to", 32'(MemTimeout), 32'h1);
    check("mw_state", 32'(State), 32'h3);
    MemReadyM = 1'b1; PCSrcE = 1'b0; MemReqM = 1'b0;
    #1;
    check("mw_done_sf", 32'(sf), 32'h0);
    step();
    check("mw_run", 32'(State), 32'h0);
    check("mw_to_sticky", 32'(MemTimeout), 32'h1);
    check("mw_scnt", 32'(StallCount), 32'd9);
    check("mw_fcnt", 32'(FlushCount), 32'd1);
    LoadE = 1'b1; RdE = 5'd3; Rs1_D = 5'd3;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", 32'(StallCount4), 32'd15);
    check("sat_cnt16", 32'(StallCount), 32'd29);
    step();
    check("sat_hold", 32'(StallCount4), 32'd15);
    clearIn();
    MemReqM = 1'b1; RegWriteM = 1'b1; RdM = 5'd4; Rs1_E = 5'd4; PCSrcE = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("rmw_sf", 32'(sf), 32'h0);
    check("rmw_fwd", 32'(ForwardAE), 32'h0);
    step();
    check("rmw_state", 32'(State), 32'h0);
    check("rmw_cnt", 32'({StallCount, FlushCount}), 32'h0);
    check("rmw_to", 32'(MemTimeout), 32'h0);
    rst = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("rmw_no_residue", 32'(MemTimeout), 32'h0);
    step();
    check("rmw_to_again", 32'(MemTimeout), 32'h1);
    check("rmw_scnt", 32'(StallCount), 32'd8);
    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end
endmodule
